btn_event_decoder: RTL

Consumes the clean, debounced button level produced upstream and classifies button activity into one-cycle event pulses: press, release, single click, double click and long press. Sits between the debouncer instance and the application control logic (mode switching, menu stepping), so downstream logic reacts to events rather than to levels. All outputs are registered. All timing is counted in clock cycles.

---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_event_decoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button event decoder: state encoding, timing
// defaults and a small constant helper used for counter sizing.
package btn_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_PRESS1   = 3'd1;
    localparam state_t ST_WAIT_GAP = 3'd2;
    localparam state_t ST_PRESS2   = 3'd3;
    localparam state_t ST_LONG     = 3'd4;

    localparam int unsigned LONG_CLOCKS_DEF = 32'd50_000_000;
    localparam int unsigned GAP_CLOCKS_DEF  = 32'd15_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            max_u = a;
        end else begin
            max_u = b;
        end
    endfunction

endpackage

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into press/release/click/double/long
// pulses using a single FSM and one shared cycle counter.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CLOCKS = LONG_CLOCKS_DEF,
    parameter int unsigned GAP_CLOCKS  = GAP_CLOCKS_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic double_o,
    output logic long_o,
    output logic held_o
);

    localparam int unsigned CNT_W = $clog2(max_u(LONG_CLOCKS, GAP_CLOCKS));
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CLOCKS - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CLOCKS - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

    // Next-state, counter and event decision for the current sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (btn_i) begin
                    state_d = ST_PRESS1;
                    press_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (!btn_i) begin
                    state_d   = ST_WAIT_GAP;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = CNT_ZERO;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_GAP: begin
                // A press on the expiry sample still counts as the second press.
                if (btn_i) begin
                    state_d = ST_PRESS2;
                    cnt_d   = CNT_ZERO;
                    press_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    click_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (!btn_i) begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                    double_d  = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = CNT_ZERO;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LONG: begin
                cnt_d = CNT_ZERO;
                if (!btn_i) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else begin
                    state_d = ST_LONG;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        held_d = (state_d == ST_PRESS1) || (state_d == ST_PRESS2) || (state_d == ST_LONG);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            double_q  <= double_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign click_o   = click_q;
    assign double_o  = double_q;
    assign long_o    = long_q;
    assign held_o    = held_q;

endmodule
